// File: rtl/varredura_pkg.sv
// Shared types and constants for the comparator sweep engine.
package varredura_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      ESPERA  = 2'd1,
      AMOSTRA = 2'd2,
      FIM     = 2'd3
   } estado_t;

   // Width of the settle counter; bounds SETTLE to 0..15.
   localparam int CNT_W = 4;

   function automatic int n_codigos(input int width);
      return 2 ** width;
   endfunction

endpackage

// File: rtl/codificador_prioridade.sv
// Combinational priority encoder: index of the lowest set bit plus a valid flag.
module codificador_prioridade #(
   parameter  int WIDTH = 4,
   localparam int N     = 2 ** WIDTH
) (
   input  logic [N-1:0]     i_vetor,
   output logic [WIDTH-1:0] o_indice,
   output logic             o_valido
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      o_indice = '0;
      o_valido = |i_vetor;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vetor[i]) o_indice = WIDTH'(i);
      end
   end

endmodule

// File: rtl/varredura_comparador.sv
// Sweeps X through every code, samples Q into a response map and checks it
// against a mask latched at start.
module varredura_comparador
   import varredura_pkg::*;
#(
   parameter  int WIDTH  = 4,
   parameter  int SETTLE = 1,
   localparam int N      = n_codigos(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     esperado,
   output logic [WIDTH-1:0] X,
   input  logic             Q,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     mapa,
   output logic             ok,
   output logic             erro_valido,
   output logic [WIDTH-1:0] primeiro_erro
);

   estado_t          r_estado;
   estado_t          w_prox;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_x;
   logic [N-1:0]     r_mapa;
   logic [N-1:0]     r_esp;
   logic             r_done;
   logic             r_ok;
   logic             r_erro;
   logic [WIDTH-1:0] r_primeiro;

   logic             w_inicia;
   logic             w_ultimo;
   logic [N-1:0]     w_dif;
   logic [WIDTH-1:0] w_indice;
   logic             w_valido;

   // With SETTLE=0 there is no wait state: each code is sampled right away.
   localparam estado_t APOS_CODIGO = (SETTLE == 0) ? AMOSTRA : ESPERA;

   always_ff @(posedge clk) begin
      if (rst) r_estado <= OCIOSO;
      else     r_estado <= w_prox;
   end

   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         OCIOSO:  if (start) w_prox = APOS_CODIGO;
         ESPERA:  if (r_cnt == CNT_W'(1)) w_prox = AMOSTRA;
         AMOSTRA: w_prox = w_ultimo ? FIM : APOS_CODIGO;
         FIM:     w_prox = OCIOSO;
         default: w_prox = OCIOSO;
      endcase
   end

   always_comb begin
      w_inicia = (r_estado == OCIOSO) && start;
      w_ultimo = (r_x == WIDTH'(N - 1));
      busy     = (r_estado != OCIOSO);
   end

   // The map includes the final AMOSTRA write by the time FIM compares it.
   assign w_dif = r_mapa ^ r_esp;

   codificador_prioridade #(.WIDTH(WIDTH)) u_prio (
      .i_vetor  (w_dif),
      .o_indice (w_indice),
      .o_valido (w_valido)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_x        <= '0;
         r_mapa     <= '0;
         r_esp      <= '0;
         r_done     <= 1'b0;
         r_ok       <= 1'b0;
         r_erro     <= 1'b0;
         r_primeiro <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_estado)
            OCIOSO: begin
               if (w_inicia) begin
                  r_x    <= '0;
                  r_mapa <= '0;
                  r_esp  <= esperado;
                  r_cnt  <= CNT_W'(SETTLE);
               end
            end
            ESPERA: r_cnt <= r_cnt - CNT_W'(1);
            AMOSTRA: begin
               r_mapa[r_x] <= Q;
               if (!w_ultimo) begin
                  r_x   <= r_x + WIDTH'(1);
                  r_cnt <= CNT_W'(SETTLE);
               end
            end
            FIM: begin
               r_done     <= 1'b1;
               r_erro     <= w_valido;
               r_ok       <= ~w_valido;
               r_primeiro <= w_indice;
            end
            default: ;
         endcase
      end
   end

   assign X             = r_x;
   assign done          = r_done;
   assign mapa          = r_mapa;
   assign ok            = r_ok;
   assign erro_valido   = r_erro;
   assign primeiro_erro = r_primeiro;

endmodule

// File: tb/tb_varredura_comparador.sv
// Directed bench: three sweep engines (SETTLE=1,0,3) driving a threshold comparator model.
module tb_varredura_comparador;

   logic             clk;
   logic             rst;
   logic             reg_mode;
   logic [15:0]      esperado;
   logic [2:0]       st, qv, rq, dn, bs, okv, ev;
   logic [2:0][3:0]  xs, pe;
   logic [2:0][15:0] mp;

   int checks   = 0;
   int failures = 0;
   int lat, nbusy, holdbad, ntrans, ndone, c;
   logic [15:0] pre_mapa;
   logic        pre_ok;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Comparator model: Q = (X >= 10), optionally registered one cycle late.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) rq[k] <= (xs[k] >= 4'd10);
   end
   always_comb begin
      for (int k = 0; k < 3; k++) qv[k] = reg_mode ? rq[k] : (xs[k] >= 4'd10);
   end

   varredura_comparador #(.WIDTH(4), .SETTLE(1)) d1 (
      .clk(clk), .rst(rst), .start(st[0]), .esperado(esperado), .X(xs[0]), .Q(qv[0]),
      .busy(bs[0]), .done(dn[0]), .mapa(mp[0]), .ok(okv[0]), .erro_valido(ev[0]),
      .primeiro_erro(pe[0]));
   varredura_comparador #(.WIDTH(4), .SETTLE(0)) d0 (
      .clk(clk), .rst(rst), .start(st[1]), .esperado(esperado), .X(xs[1]), .Q(qv[1]),
      .busy(bs[1]), .done(dn[1]), .mapa(mp[1]), .ok(okv[1]), .erro_valido(ev[1]),
      .primeiro_erro(pe[1]));
   varredura_comparador #(.WIDTH(4), .SETTLE(3)) d3 (
      .clk(clk), .rst(rst), .start(st[2]), .esperado(esperado), .X(xs[2]), .Q(qv[2]),
      .busy(bs[2]), .done(dn[2]), .mapa(mp[2]), .ok(okv[2]), .erro_valido(ev[2]),
      .primeiro_erro(pe[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int settle_of(input int s);
      case (s)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   // One-cycle start pulse, then run until done while tracking latency, busy and X hold times.
   task automatic sweep(input int s, input logic [15:0] esp);
      int run;
      logic [3:0] px;
      esperado = esp;
      st[s] = 1'b1;
      tick();
      st[s] = 1'b0;
      pre_mapa = mp[s];
      pre_ok   = okv[s];
      lat = 0; nbusy = 0; holdbad = 0; ntrans = 0;
      run = 1;
      px  = xs[s];
      while (!dn[s] && lat < 200) begin
         if (bs[s]) nbusy++;
         tick();
         lat++;
         if (xs[s] == px) run++;
         else begin
            if (run != settle_of(s) + 1) holdbad++;
            ntrans++;
            run = 1;
            px  = xs[s];
         end
      end
      chk("done_seen", {31'd0, dn[s]}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; st = '0; esperado = '0; reg_mode = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("rst_x",    {28'd0, xs[0]}, 32'd0);
      chk("rst_busy", {31'd0, bs[0]}, 32'd0);
      chk("rst_done", {31'd0, dn[0]}, 32'd0);
      chk("rst_mapa", {16'd0, mp[0]}, 32'd0);
      chk("rst_ok",   {31'd0, okv[0]}, 32'd0);
      chk("rst_ev",   {31'd0, ev[0]}, 32'd0);
      chk("rst_pe",   {28'd0, pe[0]}, 32'd0);

      // 1: matching mask, SETTLE=1
      sweep(0, 16'hFC00);
      chk("t1_lat",  lat, 32'd33);
      chk("t1_busy", nbusy, 32'd33);
      chk("t1_mapa", {16'd0, mp[0]}, 32'h0000FC00);
      chk("t1_ok",   {31'd0, okv[0]}, 32'd1);
      chk("t1_ev",   {31'd0, ev[0]}, 32'd0);
      chk("t1_pe",   {28'd0, pe[0]}, 32'd0);
      chk("t1_x_hold", {28'd0, xs[0]}, 32'd15);
      tick();
      chk("t1_done_pulse", {31'd0, dn[0]}, 32'd0);
      chk("t1_busy_end",   {31'd0, bs[0]}, 32'd0);

      // 2: mask with an extra bit at code 9
      sweep(0, 16'hFE00);
      chk("t2_clear_mapa", {16'd0, pre_mapa}, 32'd0);
      chk("t2_ok_held",    {31'd0, pre_ok}, 32'd1);
      chk("t2_ok",   {31'd0, okv[0]}, 32'd0);
      chk("t2_ev",   {31'd0, ev[0]}, 32'd1);
      chk("t2_pe",   {28'd0, pe[0]}, 32'd9);
      chk("t2_mapa", {16'd0, mp[0]}, 32'h0000FC00);
      tick();

      // 3: start held high, esperado changed mid-sweep
      esperado = 16'hFC00;
      st[0] = 1'b1;
      tick();
      lat = 0;
      while (!dn[0] && lat < 200) begin
         tick();
         lat++;
         if (xs[0] == 4'd7) esperado = 16'h0000;
      end
      chk("t3_lat",  lat, 32'd33);
      chk("t3_ok",   {31'd0, okv[0]}, 32'd1);
      chk("t3_mapa", {16'd0, mp[0]}, 32'h0000FC00);
      tick();
      chk("t3_restart_busy", {31'd0, bs[0]}, 32'd1);
      chk("t3_restart_x",    {28'd0, xs[0]}, 32'd0);
      chk("t3_restart_mapa", {16'd0, mp[0]}, 32'd0);
      chk("t3_restart_done", {31'd0, dn[0]}, 32'd0);
      st[0] = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dn[0]) ndone++;
      end
      chk("t3_ndone", ndone, 32'd1);
      chk("t3_ok2",   {31'd0, okv[0]}, 32'd0);
      chk("t3_pe2",   {28'd0, pe[0]}, 32'd10);

      // 4: reset in mid-sweep at X=5
      esperado = 16'hFC00;
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      c = 0;
      while (xs[0] != 4'd5 && c < 50) begin
         tick();
         c++;
      end
      chk("t4_reach_x5", {28'd0, xs[0]}, 32'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_x",    {28'd0, xs[0]}, 32'd0);
      chk("t4_busy", {31'd0, bs[0]}, 32'd0);
      chk("t4_mapa", {16'd0, mp[0]}, 32'd0);
      chk("t4_done", {31'd0, dn[0]}, 32'd0);
      chk("t4_ok",   {31'd0, okv[0]}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dn[0] || bs[0]) ndone++;
      end
      chk("t4_quiet", ndone, 32'd0);
      sweep(0, 16'hFC00);
      chk("t4_lat", lat, 32'd33);
      chk("t4_ok2", {31'd0, okv[0]}, 32'd1);

      // 5: SETTLE=0 and SETTLE=3 latency and X hold times
      sweep(1, 16'hFC00);
      chk("t5_s0_lat",   lat, 32'd17);
      chk("t5_s0_hold",  holdbad, 32'd0);
      chk("t5_s0_trans", ntrans, 32'd15);
      chk("t5_s0_ok",    {31'd0, okv[1]}, 32'd1);
      sweep(2, 16'hFC00);
      chk("t5_s3_lat",   lat, 32'd65);
      chk("t5_s3_hold",  holdbad, 32'd0);
      chk("t5_s3_trans", ntrans, 32'd15);
      chk("t5_s3_busy",  nbusy, 32'd65);
      chk("t5_s3_ok",    {31'd0, okv[2]}, 32'd1);

      // 6: registered comparator, Q lags X by one cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      reg_mode = 1'b1;
      tick(); tick(); tick();
      sweep(1, 16'hFC00);
      chk("t6_s0_mapa", {16'd0, mp[1]}, 32'h0000F800);
      chk("t6_s0_ok",   {31'd0, okv[1]}, 32'd0);
      chk("t6_s0_ev",   {31'd0, ev[1]}, 32'd1);
      chk("t6_s0_pe",   {28'd0, pe[1]}, 32'd10);
      sweep(0, 16'hFC00);
      chk("t6_s1_mapa", {16'd0, mp[0]}, 32'h0000FC00);
      chk("t6_s1_ok",   {31'd0, okv[0]}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
